// File: rtl/ahblite_master_arb.sv
// ahblite_master_arb
//   Two-master AHB-Lite arbiter with no added latency. One master owns the
//   shared address phase (GNT). Ownership moves only when the owner is IDLE,
//   the slave is ready and the other master is requesting. With no request
//   pending, the current owner keeps the bus. The data-phase owner (DOWN,
//   DVALID) is tracked separately. This lets write data and responses follow
//   the master whose transfer is actually completing.
//   A saturating wait counter measures how long the non-owner has been held
//   off. It raises a sticky starvation flag when the count reaches STARVE_LIM.
//
// Parameters
//   STARVE_LIM   wait-cycle count that flags starvation (1..255)
//
// Ports
//   HCLK, HRESETn                 bus clock, asynchronous active-low reset
//   Mx_HADDR/HTRANS/HWRITE/HSIZE  address phase from master x
//   Mx_HWDATA                     write data from master x
//   Mx_HRDATA                     read data to master x (HRDATA broadcast)
//   Mx_HREADY, Mx_HRESP           per-master ready and response
//   HADDR/HTRANS/HWRITE/HSIZE     shared address phase to the decoder
//   HWDATA                        shared write data to the decoder
//   HRDATA, HREADY, HRESP         muxed slave response from the decoder
//   HMASTER                       current address-phase owner (0=M0, 1=M1)
//   ARB_STARVE, STARVE_CLR        sticky starvation flag and its clear
//
// Build option
//   ARB_LOCK_EN  adds Mx_HMASTLOCK inputs and an HMASTLOCK output. A locked
//                owner keeps the bus even while it is IDLE.

module ahblite_master_arb #(
  parameter int unsigned STARVE_LIM = 64
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HREADY,
  output logic        M0_HRESP,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HREADY,
  output logic        M1_HRESP,
`ifdef ARB_LOCK_EN
  input  logic        M0_HMASTLOCK,
  input  logic        M1_HMASTLOCK,
  output logic        HMASTLOCK,
`endif
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        HMASTER,
  output logic        ARB_STARVE,
  input  logic        STARVE_CLR
);

  localparam logic [7:0] StarveLim = 8'(STARVE_LIM);

  logic       gnt_q, gnt_d;
  logic       down_q, down_d;
  logic       dvalid_q, dvalid_d;
  logic       starve_q, starve_d;
  logic [7:0] waitCnt_q, waitCnt_d;

  logic m0Req, m1Req, otherReq, ownerIdle, ownerLocked, handover, starveSet;
  logic m0Sel, m1Sel;

  assign m0Req = M0_HTRANS[1];
  assign m1Req = M1_HTRANS[1];

  // Address phase comes straight from the owner, so a grant costs no cycle.
  always_comb begin
    if (gnt_q) begin
      HADDR  = M1_HADDR;
      HTRANS = M1_HTRANS;
      HWRITE = M1_HWRITE;
      HSIZE  = M1_HSIZE;
    end else begin
      HADDR  = M0_HADDR;
      HTRANS = M0_HTRANS;
      HWRITE = M0_HWRITE;
      HSIZE  = M0_HSIZE;
    end
  end

  // Write data belongs to the data phase, which may lag a handover by a cycle.
  assign HWDATA    = down_q ? M1_HWDATA : M0_HWDATA;
  assign M0_HRDATA = HRDATA;
  assign M1_HRDATA = HRDATA;

`ifdef ARB_LOCK_EN
  assign HMASTLOCK   = gnt_q ? M1_HMASTLOCK : M0_HMASTLOCK;
  assign ownerLocked = HMASTLOCK;
`else
  assign ownerLocked = 1'b0;
`endif

  // Only a true IDLE hands the bus over. BUSY keeps the owner's burst intact.
  assign ownerIdle = (HTRANS == 2'b00);
  assign otherReq  = gnt_q ? m0Req : m1Req;
  assign handover  = HREADY && ownerIdle && otherReq && !ownerLocked;

  // A master sees the real slave handshake while it owns the address phase
  // or has a data phase in flight. Otherwise a requester is stalled (held
  // with its address) and an idle master sees ready.
  assign m0Sel     = !gnt_q || (dvalid_q && !down_q);
  assign m1Sel     =  gnt_q || (dvalid_q &&  down_q);
  assign M0_HREADY = m0Sel ? HREADY : !m0Req;
  assign M1_HREADY = m1Sel ? HREADY : !m1Req;
  assign M0_HRESP  = m0Sel ? HRESP : 1'b0;
  assign M1_HRESP  = m1Sel ? HRESP : 1'b0;

  // Next-state: grant toggle, data-phase tracking and starvation bookkeeping.
  // The flag is set only on the cycle the count first reaches the limit, so a
  // saturated counter cannot re-raise it after a clear.
  always_comb begin
    gnt_d    = gnt_q ^ handover;
    down_d   = down_q;
    dvalid_d = dvalid_q;
    if (HREADY) begin
      down_d   = gnt_q;
      dvalid_d = HTRANS[1];
    end

    waitCnt_d = waitCnt_q;
    if (!otherReq || handover) begin
      waitCnt_d = '0;
    end else if (waitCnt_q != 8'hFF) begin
      waitCnt_d = waitCnt_q + 8'd1;
    end

    starveSet = (waitCnt_d == StarveLim) && (waitCnt_q != StarveLim);
    starve_d  = starve_q;
    if (STARVE_CLR) begin
      starve_d = 1'b0;
    end else if (starveSet) begin
      starve_d = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      gnt_q     <= 1'b0;
      down_q    <= 1'b0;
      dvalid_q  <= 1'b0;
      waitCnt_q <= '0;
      starve_q  <= 1'b0;
    end else begin
      gnt_q     <= gnt_d;
      down_q    <= down_d;
      dvalid_q  <= dvalid_d;
      waitCnt_q <= waitCnt_d;
      starve_q  <= starve_d;
    end
  end

  assign HMASTER    = gnt_q;
  assign ARB_STARVE = starve_q;

endmodule
